// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants, write-record type and packed-field offset helpers
// for the register-file write-port arbiter.
package rf_write_arbiter_pkg;

    localparam int RF_ARB_N_REQ = 4;
    localparam int RF_DATA_W    = 16;
    localparam int RF_ADDR_W    = 4;
    localparam int RF_ID_W      = 2;
    localparam int RF_EN_W      = 1 << RF_ADDR_W;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;
    typedef logic [RF_ID_W-1:0]   rf_id_t;

    // Low bit of requester i's field inside the packed req_addr / req_data buses.
    function automatic int addr_lo(input int i);
        return i * RF_ADDR_W;
    endfunction

    function automatic int data_lo(input int i);
        return i * RF_DATA_W;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Request and register-file write bus of the write-port arbiter.
// master = requesters / register file side, slave = arbiter.
interface rf_write_arbiter_if;
    import rf_write_arbiter_pkg::*;

    logic [RF_ARB_N_REQ-1:0]           req_valid;
    logic [RF_ARB_N_REQ*RF_ADDR_W-1:0] req_addr;
    logic [RF_ARB_N_REQ*RF_DATA_W-1:0] req_data;
    logic [RF_ARB_N_REQ-1:0]           req_ready;
    logic                              wr_stall;
    logic                              wr_valid;
    rf_addr_t                          wr_addr;
    rf_data_t                          wr_data;
    logic [RF_EN_W-1:0]                wr_en;
    rf_id_t                            grant_id;

    modport master (
        output req_valid, req_addr, req_data, wr_stall,
        input  req_ready, wr_valid, wr_addr, wr_data, wr_en, grant_id
    );

    modport slave (
        input  req_valid, req_addr, req_data, wr_stall,
        output req_ready, wr_valid, wr_addr, wr_data, wr_en, grant_id
    );

endinterface

// File: rtl/rf_write_arbiter_decoder.sv
// decoder4to16: 4-to-16 line decoder built from two enabled 3-to-8 halves.
// Output is always one-hot; callers gate it with their own valid.
module decoder4to16 (
    input  logic [3:0]  A,
    output logic [15:0] D
);

    logic       en_lo;
    logic       en_hi;
    logic [7:0] onehot8;

    assign en_lo   = ~A[3];
    assign en_hi   = A[3];
    assign onehot8 = 8'b0000_0001 << A[2:0];

    assign D[7:0]  = en_lo ? onehot8 : 8'h00;
    assign D[15:8] = en_hi ? onehot8 : 8'h00;

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin register-file write-port arbiter with registered write output.
// Define RF_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest).
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int N_REQ  = RF_ARB_N_REQ,
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    rf_write_arbiter_if.slave  rf_io
);

    logic [RF_ID_W-1:0] search_base;
    logic [RF_ID_W-1:0] idx;
    logic [RF_ID_W-1:0] grant_idx;
    logic               found;
    logic               xfer;
    logic [N_REQ-1:0]   ready;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    logic               wr_valid_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [DATA_W-1:0]  wr_data_q;
    logic [RF_ID_W-1:0] grant_id_q;
    logic [15:0]        dec_d;

`ifdef RF_ARB_FIXED_PRIO_EN
    assign search_base = '0;
`else
    logic [RF_ID_W-1:0] ptr_q;
    logic [RF_ID_W-1:0] ptr_d;

    assign search_base = ptr_q;
    assign ptr_d       = xfer ? grant_idx + 2'd1 : ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = search_base + 2'(k);
            if (!found && rf_io.req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // Stall and reset both suppress the grant; the transfer is exactly ready & valid.
    assign xfer = found & ~rf_io.wr_stall & ~rst;

    always_comb begin
        ready = '0;
        if (xfer) begin
            ready[grant_idx] = 1'b1;
        end
    end

    assign sel_addr = rf_io.req_addr[addr_lo(int'(grant_idx)) +: ADDR_W];
    assign sel_data = rf_io.req_data[data_lo(int'(grant_idx)) +: DATA_W];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            grant_id_q <= '0;
        end else begin
            wr_valid_q <= xfer;
            if (xfer) begin
                wr_addr_q  <= sel_addr;
                wr_data_q  <= sel_data;
                grant_id_q <= grant_idx;
            end
        end
    end

    decoder4to16 u_dec (
        .A (wr_addr_q),
        .D (dec_d)
    );

    // The decoder is never all-zero, so the strobe must gate it.
    assign rf_io.wr_en     = dec_d & {16{wr_valid_q}};
    assign rf_io.req_ready = ready;
    assign rf_io.wr_valid  = wr_valid_q;
    assign rf_io.wr_addr   = wr_addr_q;
    assign rf_io.wr_data   = wr_data_q;
    assign rf_io.grant_id  = grant_id_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: vector table plus hand sequences,
// registered writes checked against a scoreboard queue.
module tb_rf_write_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rf_write_arbiter_if bus ();

    rf_write_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .rf_io (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] data;
        logic [1:0]  id;
    } exp_t;

    typedef struct packed {
        logic [3:0] valid;
        logic       stall;
        logic [3:0] exp_rr;
        logic [3:0] exp_fp;
    } vec_t;

    localparam int N_VEC = 23;

    vec_t vecs [N_VEC];
    exp_t sb [$];
    exp_t last_wr = '0;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Registered outputs compared against the scoreboard head, or against "idle, hold".
    task automatic check_outputs(input string name);
        exp_t       e;
        logic [15:0] one;
        one = 16'h0001;
        if (sb.size() > 0) begin
            e       = sb.pop_front();
            last_wr = e;
            check({name, " wr_valid"}, 64'(bus.wr_valid), 64'(1'b1));
            check({name, " wr_addr"},  64'(bus.wr_addr),  64'(e.addr));
            check({name, " wr_data"},  64'(bus.wr_data),  64'(e.data));
            check({name, " grant_id"}, 64'(bus.grant_id), 64'(e.id));
            check({name, " wr_en"},    64'(bus.wr_en),    64'(one << e.addr));
        end else begin
            check({name, " idle wr_valid"}, 64'(bus.wr_valid), 64'(1'b0));
            check({name, " idle wr_en"},    64'(bus.wr_en),    64'(16'h0000));
            check({name, " hold wr_addr"},  64'(bus.wr_addr),  64'(last_wr.addr));
            check({name, " hold wr_data"},  64'(bus.wr_data),  64'(last_wr.data));
            check({name, " hold grant_id"}, 64'(bus.grant_id), 64'(last_wr.id));
        end
    endtask

    // One cycle: drive, check the combinational grant, predict, clock, check outputs.
    task automatic step(input logic [3:0] v, input logic s, input logic [15:0] a,
                        input logic [63:0] d, input logic [3:0] exp_ready, input string name);
        exp_t e;
        int   g;
        bus.req_valid = v;
        bus.wr_stall  = s;
        bus.req_addr  = a;
        bus.req_data  = d;
        #1;
        check({name, " req_ready"}, 64'(bus.req_ready), 64'(exp_ready));
        if (exp_ready != 4'b0000) begin
            g = 0;
            for (int i = 0; i < 4; i++) begin
                if (exp_ready[i]) g = i;
            end
            e.addr = a[g*4 +: 4];
            e.data = d[g*16 +: 16];
            e.id   = 2'(g);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        check_outputs(name);
    endtask

    task automatic check_reset_state(input string name);
        check({name, " req_ready"}, 64'(bus.req_ready), 64'(4'b0000));
        check({name, " wr_valid"},  64'(bus.wr_valid),  64'(1'b0));
        check({name, " wr_en"},     64'(bus.wr_en),     64'(16'h0000));
        check({name, " wr_addr"},   64'(bus.wr_addr),   64'(4'h0));
        check({name, " wr_data"},   64'(bus.wr_data),   64'(16'h0000));
        check({name, " grant_id"},  64'(bus.grant_id),  64'(2'd0));
    endtask

    initial begin
        logic [15:0] a;
        logic [63:0] d;
        logic [3:0]  exp_ready;
        logic [3:0]  coll_second_valid;
        logic [3:0]  coll_first_ready;
        logic [3:0]  coll_second_ready;
        logic [15:0] coll_first_data;
        logic [15:0] coll_second_data;
        logic [3:0]  after_reset_second;
        logic [3:0]  mid_reset_ready;

        // Pointer evolution (round-robin) noted as ptr after each row.
        vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 4'b0001}; // ptr 1
        vecs[1]  = '{4'b0100, 1'b0, 4'b0100, 4'b0100}; // ptr 3
        vecs[2]  = '{4'b1111, 1'b0, 4'b1000, 4'b0001}; // ptr 0
        vecs[3]  = '{4'b1111, 1'b0, 4'b0001, 4'b0001}; // ptr 1
        vecs[4]  = '{4'b1111, 1'b0, 4'b0010, 4'b0001}; // ptr 2
        vecs[5]  = '{4'b1111, 1'b0, 4'b0100, 4'b0001}; // ptr 3
        vecs[6]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000}; // ptr 3
        vecs[7]  = '{4'b0011, 1'b0, 4'b0001, 4'b0001}; // ptr 1
        vecs[8]  = '{4'b0011, 1'b1, 4'b0000, 4'b0000}; // stall, ptr 1
        vecs[9]  = '{4'b0011, 1'b1, 4'b0000, 4'b0000};
        vecs[10] = '{4'b0011, 1'b1, 4'b0000, 4'b0000};
        vecs[11] = '{4'b0011, 1'b0, 4'b0010, 4'b0001}; // ptr 2
        vecs[12] = '{4'b1010, 1'b0, 4'b1000, 4'b0010}; // ptr 0
        vecs[13] = '{4'b1010, 1'b0, 4'b0010, 4'b0010}; // ptr 2
        vecs[14] = '{4'b1010, 1'b0, 4'b1000, 4'b0010}; // ptr 0
        vecs[15] = '{4'b1111, 1'b0, 4'b0001, 4'b0001};
        vecs[16] = '{4'b1111, 1'b0, 4'b0010, 4'b0001};
        vecs[17] = '{4'b1111, 1'b0, 4'b0100, 4'b0001};
        vecs[18] = '{4'b1111, 1'b0, 4'b1000, 4'b0001};
        vecs[19] = '{4'b1111, 1'b0, 4'b0001, 4'b0001};
        vecs[20] = '{4'b1111, 1'b0, 4'b0010, 4'b0001};
        vecs[21] = '{4'b1111, 1'b0, 4'b0100, 4'b0001};
        vecs[22] = '{4'b1111, 1'b0, 4'b1000, 4'b0001}; // ptr 0

`ifdef RF_ARB_FIXED_PRIO_EN
        coll_first_ready   = 4'b0010;
        coll_second_valid  = 4'b1000;
        coll_second_ready  = 4'b1000;
        coll_first_data    = 16'hAAAA;
        coll_second_data   = 16'h5555;
        mid_reset_ready    = 4'b0001;
        after_reset_second = 4'b0001;
`else
        coll_first_ready   = 4'b1000; // ptr 3 after the single request
        coll_second_valid  = 4'b0010;
        coll_second_ready  = 4'b0010;
        coll_first_data    = 16'h5555;
        coll_second_data   = 16'hAAAA;
        mid_reset_ready    = 4'b0100; // ptr 2 after the collision pair
        after_reset_second = 4'b0010;
`endif

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            bus.req_valid = 4'($urandom);
            bus.wr_stall  = 1'($urandom);
            bus.req_addr  = 16'($urandom);
            bus.req_data  = {$urandom, $urandom};
            #1;
            check_reset_state("reset");
        end
        rst = 1'b0;

        for (int i = 0; i < N_VEC; i++) begin
`ifdef RF_ARB_FIXED_PRIO_EN
            exp_ready = vecs[i].exp_fp;
`else
            exp_ready = vecs[i].exp_rr;
`endif
            step(vecs[i].valid, vecs[i].stall, 16'($urandom), {$urandom, $urandom},
                 exp_ready, $sformatf("vec%0d", i));
        end

        // Single request to address A from requester 2.
        a = 16'($urandom);
        a[11:8] = 4'hA;
        d = {$urandom, $urandom};
        d[47:32] = 16'h1234;
        step(4'b0100, 1'b0, a, d, 4'b0100, "single");
        check("single wr_en const", 64'(bus.wr_en), 64'(16'h0400));
        check("single wr_data const", 64'(bus.wr_data), 64'(16'h1234));
        check("single grant const", 64'(bus.grant_id), 64'(2'd2));

        // Requesters 1 and 3 both write address F.
        a = 16'($urandom);
        a[7:4]   = 4'hF;
        a[15:12] = 4'hF;
        d = {$urandom, $urandom};
        d[31:16] = 16'hAAAA;
        d[63:48] = 16'h5555;
        step(4'b1010, 1'b0, a, d, coll_first_ready, "coll first");
        check("coll first wr_en", 64'(bus.wr_en), 64'(16'h8000));
        check("coll first data", 64'(bus.wr_data), 64'(coll_first_data));
        step(coll_second_valid, 1'b0, a, d, coll_second_ready, "coll second");
        check("coll second wr_en", 64'(bus.wr_en), 64'(16'h8000));
        check("coll second data", 64'(bus.wr_data), 64'(coll_second_data));

        // Reset in the cycle after a transfer drops the write before the next edge.
        step(4'b1111, 1'b0, 16'($urandom), {$urandom, $urandom}, mid_reset_ready, "pre reset");
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("mid reset");
        last_wr = '0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            bus.req_valid = 4'($urandom);
            bus.wr_stall  = 1'($urandom);
            bus.req_addr  = 16'($urandom);
            bus.req_data  = {$urandom, $urandom};
            #1;
            check_reset_state("held reset");
        end
        rst = 1'b0;
        step(4'b1111, 1'b0, 16'($urandom), {$urandom, $urandom}, 4'b0001, "post reset first");
        step(4'b1111, 1'b0, 16'($urandom), {$urandom, $urandom}, after_reset_second, "post reset second");
        step(4'b0000, 1'b0, 16'($urandom), {$urandom, $urandom}, 4'b0000, "drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
